// File: rtl/stage_decision.sv
// rtl/stage_decision.sv - Viola-Jones per-stage threshold decision and window verdict
//
// Consumes the running fp32 stage sum from the stage-sum accumulator. It counts the
// accumulator's valid outputs for each stage and compares the final sum against the
// stage threshold. On a pass it clears the accumulator and moves to the next stage.
// On a fail, or after the last stage, it issues the verdict for the window.
//
// Optional feature macro: STAGE_DECISION_STAT_EN
//   Defined   - win_cnt_o / face_cnt_o are saturating verdict / face counters.
//   Undefined - both outputs are tied to zero.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   window_start_i      pulse, start a window at stage 0 (aborts any window in flight)
//   stage_req_o         level, requesting the parameters for stage_idx_o
//   stage_idx_o         current stage index
//   stage_thr_i         stage threshold, fp32
//   stage_len_i         number of weak classifiers in the stage
//   stage_param_val_i   qualifies stage_thr_i / stage_len_i
//   stage_sum_i         running stage sum, fp32
//   stage_sum_val_i     qualifies stage_sum_i
//   new_stage_o         pulse, clears the accumulator
//   result_val_o        pulse, verdict valid
//   result_face_o       1 = every stage passed (held until the next verdict)
//   result_stage_o      stage that rejected the window, or the last stage on a face
//   busy_o              window in progress
//   win_cnt_o           windows decided
//   face_cnt_o          faces found
module stage_decision #(
    parameter int NUM_STAGES = 22,
    parameter int STAGE_W    = 5,
    parameter int WEAK_CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  window_start_i,
    output logic                  stage_req_o,
    output logic [STAGE_W-1:0]    stage_idx_o,
    input  logic [31:0]           stage_thr_i,
    input  logic [WEAK_CNT_W-1:0] stage_len_i,
    input  logic                  stage_param_val_i,
    input  logic [31:0]           stage_sum_i,
    input  logic                  stage_sum_val_i,
    output logic                  new_stage_o,
    output logic                  result_val_o,
    output logic                  result_face_o,
    output logic [STAGE_W-1:0]    result_stage_o,
    output logic                  busy_o,
    output logic [31:0]           win_cnt_o,
    output logic [31:0]           face_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_ACCUM   = 2'd2,
        S_COMPARE = 2'd3
    } state_t;

    localparam logic [STAGE_W-1:0] LAST_IDX = STAGE_W'(NUM_STAGES - 1);

    state_t                  state;
    logic [31:0]             thr_q;
    logic [31:0]             last_sum_q;
    logic [WEAK_CNT_W-1:0]   len_q;
    logic [WEAK_CNT_W-1:0]   cnt_q;

    // a >= b for fp32 operands. NaN and denormal inputs are not handled.
    function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
        logic res;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
            res = 1'b1;                         // +0 and -0 compare equal
        else if (a[31] != b[31])
            res = ~a[31];                       // positive side wins
        else if (!a[31])
            res = (a[30:0] >= b[30:0]);         // both positive: magnitude order
        else
            res = (a[30:0] <= b[30:0]);         // both negative: magnitude order reversed
        return res;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            stage_req_o    <= 1'b0;
            stage_idx_o    <= '0;
            new_stage_o    <= 1'b0;
            result_val_o   <= 1'b0;
            result_face_o  <= 1'b0;
            result_stage_o <= '0;
            busy_o         <= 1'b0;
            thr_q          <= '0;
            last_sum_q     <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
        end else begin
            new_stage_o  <= 1'b0;
            result_val_o <= 1'b0;

            // A window start restarts from any state and drops the window in flight.
            if (window_start_i) begin
                state       <= S_LOAD;
                stage_idx_o <= '0;
                new_stage_o <= 1'b1;
                stage_req_o <= 1'b1;
                busy_o      <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end

                    S_LOAD: begin
                        if (stage_param_val_i) begin
                            thr_q       <= stage_thr_i;
                            len_q       <= stage_len_i;
                            cnt_q       <= '0;
                            last_sum_q  <= '0;
                            stage_req_o <= 1'b0;
                            // An empty stage is judged on a sum of +0.0.
                            state <= (stage_len_i == '0) ? S_COMPARE : S_ACCUM;
                        end
                    end

                    S_ACCUM: begin
                        if (stage_sum_val_i) begin
                            last_sum_q <= stage_sum_i;
                            cnt_q      <= cnt_q + 1'b1;
                            if ((cnt_q + 1'b1) == len_q)
                                state <= S_COMPARE;
                        end
                    end

                    S_COMPARE: begin
                        if (fp_ge(last_sum_q, thr_q) && (stage_idx_o < LAST_IDX)) begin
                            stage_idx_o <= stage_idx_o + 1'b1;
                            new_stage_o <= 1'b1;
                            stage_req_o <= 1'b1;
                            state       <= S_LOAD;
                        end else begin
                            result_val_o   <= 1'b1;
                            result_face_o  <= fp_ge(last_sum_q, thr_q);
                            result_stage_o <= stage_idx_o;
                            busy_o         <= 1'b0;
                            state          <= S_IDLE;
                        end
                    end

                    default: begin
                        state       <= S_IDLE;
                        stage_req_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef STAGE_DECISION_STAT_EN
    logic [31:0] win_cnt_q;
    logic [31:0] face_cnt_q;

    // Counted on the registered verdict pulse, saturating, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_cnt_q  <= '0;
            face_cnt_q <= '0;
        end else if (result_val_o) begin
            if (win_cnt_q != 32'hFFFF_FFFF)
                win_cnt_q <= win_cnt_q + 32'd1;
            if (result_face_o && (face_cnt_q != 32'hFFFF_FFFF))
                face_cnt_q <= face_cnt_q + 32'd1;
        end
    end

    assign win_cnt_o  = win_cnt_q;
    assign face_cnt_o = face_cnt_q;
`else
    assign win_cnt_o  = '0;
    assign face_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stage_decision.sv
// tb/tb_stage_decision.sv - directed self-checking bench for stage_decision
module tb_stage_decision;

    localparam int NS = 3;
    localparam int SW = 5;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          window_start_i;
    logic          stage_req_o;
    logic [SW-1:0] stage_idx_o;
    logic [31:0]   stage_thr_i;
    logic [WW-1:0] stage_len_i;
    logic          stage_param_val_i;
    logic [31:0]   stage_sum_i;
    logic          stage_sum_val_i;
    logic          new_stage_o;
    logic          result_val_o;
    logic          result_face_o;
    logic [SW-1:0] result_stage_o;
    logic          busy_o;
    logic [31:0]   win_cnt_o;
    logic [31:0]   face_cnt_o;

    int checks = 0;
    int errors = 0;

    stage_decision #(.NUM_STAGES(NS), .STAGE_W(SW), .WEAK_CNT_W(WW)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .window_start_i   (window_start_i),
        .stage_req_o      (stage_req_o),
        .stage_idx_o      (stage_idx_o),
        .stage_thr_i      (stage_thr_i),
        .stage_len_i      (stage_len_i),
        .stage_param_val_i(stage_param_val_i),
        .stage_sum_i      (stage_sum_i),
        .stage_sum_val_i  (stage_sum_val_i),
        .new_stage_o      (new_stage_o),
        .result_val_o     (result_val_o),
        .result_face_o    (result_face_o),
        .result_stage_o   (result_stage_o),
        .busy_o           (busy_o),
        .win_cnt_o        (win_cnt_o),
        .face_cnt_o       (face_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_window();
        window_start_i = 1'b1;
        tick();
        window_start_i = 1'b0;
    endtask

    // Waits (bounded) for a parameter request, then answers it for one cycle.
    task automatic give_params(input logic [31:0] thr, input logic [WW-1:0] len);
        int n = 0;
        while (!stage_req_o && n < 20) begin
            tick();
            n++;
        end
        chk("req_wait", {31'd0, stage_req_o}, 32'd1);
        stage_thr_i       = thr;
        stage_len_i       = len;
        stage_param_val_i = 1'b1;
        tick();
        stage_param_val_i = 1'b0;
    endtask

    task automatic give_sum(input logic [31:0] s);
        stage_sum_i     = s;
        stage_sum_val_i = 1'b1;
        tick();
        stage_sum_val_i = 1'b0;
    endtask

    // Three stages with thr 1.0, len 2, sums 0.5 then 2.0: a face at stage 2.
    task automatic face_window(input string tag);
        start_window();
        chk({tag, "_ns0"}, {31'd0, new_stage_o}, 32'd1);
        for (int s = 0; s < NS; s++) begin
            give_params(32'h3F80_0000, 8'd2);
            give_sum(32'h3F00_0000);
            give_sum(32'h4000_0000);
            chk({tag, "_cmp_noval"}, {31'd0, result_val_o}, 32'd0);
            tick();
            if (s < NS - 1) begin
                chk({tag, "_mid_ns"}, {31'd0, new_stage_o}, 32'd1);
                chk({tag, "_mid_idx"}, {27'd0, stage_idx_o}, s + 1);
                chk({tag, "_mid_noval"}, {31'd0, result_val_o}, 32'd0);
            end
        end
        chk({tag, "_val"}, {31'd0, result_val_o}, 32'd1);
        chk({tag, "_face"}, {31'd0, result_face_o}, 32'd1);
        chk({tag, "_stage"}, {27'd0, result_stage_o}, 32'd2);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        tick();
        chk({tag, "_val_pulse"}, {31'd0, result_val_o}, 32'd0);
        chk({tag, "_face_hold"}, {31'd0, result_face_o}, 32'd1);
    endtask

    initial begin
        rst_i = 1'b1;
        window_start_i = 1'b0;
        stage_thr_i = '0;
        stage_len_i = '0;
        stage_param_val_i = 1'b0;
        stage_sum_i = '0;
        stage_sum_val_i = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'd0, stage_req_o}, 32'd0);
        chk("rst_idx", {27'd0, stage_idx_o}, 32'd0);
        chk("rst_val", {31'd0, result_val_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ns", {31'd0, new_stage_o}, 32'd0);
        rst_i = 1'b0;
        tick();

        // Full face window.
        face_window("t1");

        // Stage 0 rejects: -2.0 < -1.0.
        start_window();
        chk("t2_busy", {31'd0, busy_o}, 32'd1);
        give_params(32'hBF80_0000, 8'd1);
        give_sum(32'hC000_0000);
        tick();
        chk("t2_val", {31'd0, result_val_o}, 32'd1);
        chk("t2_face", {31'd0, result_face_o}, 32'd0);
        chk("t2_stage", {27'd0, result_stage_o}, 32'd0);
        tick();
        chk("t2_noreq", {31'd0, stage_req_o}, 32'd0);

        // +0.0 >= -0.0 passes; -0.0 >= smallest positive fails.
        start_window();
        give_params(32'h8000_0000, 8'd1);
        give_sum(32'h0000_0000);
        tick();
        chk("t3_zero_pass", {31'd0, new_stage_o}, 32'd1);
        chk("t3_zero_idx", {27'd0, stage_idx_o}, 32'd1);
        give_params(32'h0000_0001, 8'd1);
        give_sum(32'h8000_0000);
        tick();
        chk("t3_neg_val", {31'd0, result_val_o}, 32'd1);
        chk("t3_neg_face", {31'd0, result_face_o}, 32'd0);
        chk("t3_neg_stage", {27'd0, result_stage_o}, 32'd1);

        // Abort mid-accumulation of stage 1.
        start_window();
        give_params(32'h3F80_0000, 8'd1);
        give_sum(32'h4000_0000);
        tick();
        chk("t4_idx1", {27'd0, stage_idx_o}, 32'd1);
        give_params(32'h3F80_0000, 8'd2);
        give_sum(32'h3F00_0000);
        start_window();
        chk("t4_ns", {31'd0, new_stage_o}, 32'd1);
        chk("t4_idx0", {27'd0, stage_idx_o}, 32'd0);
        chk("t4_req", {31'd0, stage_req_o}, 32'd1);
        chk("t4_noval", {31'd0, result_val_o}, 32'd0);

        // Sum pulse in LOAD is ignored; then an empty stage fails at once.
        give_sum(32'h4000_0000);
        chk("t5_load_req", {31'd0, stage_req_o}, 32'd1);
        chk("t5_load_idx", {27'd0, stage_idx_o}, 32'd0);
        give_params(32'h3F80_0000, 8'd0);
        tick();
        chk("t5_len0_val", {31'd0, result_val_o}, 32'd1);
        chk("t5_len0_face", {31'd0, result_face_o}, 32'd0);
        chk("t5_len0_stage", {27'd0, result_stage_o}, 32'd0);
        tick();
        give_sum(32'h4000_0000);
        tick();
        chk("t5_idle_busy", {31'd0, busy_o}, 32'd0);
        chk("t5_idle_req", {31'd0, stage_req_o}, 32'd0);
        chk("t5_idle_val", {31'd0, result_val_o}, 32'd0);

        // Fifth verdict, second face.
        face_window("t6");
        tick();
`ifdef STAGE_DECISION_STAT_EN
        chk("t6_win_cnt", win_cnt_o, 32'd5);
        chk("t6_face_cnt", face_cnt_o, 32'd2);
`else
        chk("t6_win_cnt", win_cnt_o, 32'd0);
        chk("t6_face_cnt", face_cnt_o, 32'd0);
`endif

        // Reset mid-window.
        start_window();
        give_params(32'h3F80_0000, 8'd2);
        rst_i = 1'b1;
        #2;
        chk("t7_async_busy", {31'd0, busy_o}, 32'd0);
        tick();
        chk("t7_req", {31'd0, stage_req_o}, 32'd0);
        chk("t7_idx", {27'd0, stage_idx_o}, 32'd0);
        chk("t7_face", {31'd0, result_face_o}, 32'd0);
        chk("t7_win_cnt", win_cnt_o, 32'd0);
        chk("t7_face_cnt", face_cnt_o, 32'd0);
        rst_i = 1'b0;
        tick();
        give_sum(32'h4000_0000);
        chk("t7_idle_busy", {31'd0, busy_o}, 32'd0);
        start_window();
        chk("t7_restart_ns", {31'd0, new_stage_o}, 32'd1);
        chk("t7_restart_req", {31'd0, stage_req_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
